// File: rtl/envelope_generator.sv
// ADSR envelope generator stepped once per lrclk rising edge in the bclk domain.
// Output is a non-negative signed envelope in 0..2^(BITSIZE-1)-1.
module envelope_generator #(
    parameter int BITSIZE = 16
) (
    input  logic               bclk,
    input  logic               rst_n,
    input  logic               lrclk,
    input  logic               gate,
    input  logic [BITSIZE-1:0] attack_rate,
    input  logic [BITSIZE-1:0] decay_rate,
    input  logic [BITSIZE-1:0] sustain_level,
    input  logic [BITSIZE-1:0] release_rate,
    output logic [BITSIZE-1:0] out,
    output logic [2:0]         state,
    output logic               active,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_e;

    localparam logic [BITSIZE-2:0] MAX    = '1;
    localparam logic [BITSIZE:0]   ZERO_X = '0;

    state_e             state_q, state_d;
    logic [BITSIZE-2:0] level_q, level_d;
    logic               lrclk_q;
    logic               done_q, done_d;
    logic               active_q, active_d;

    logic               tick;
    logic [BITSIZE-2:0] sus_lvl;
    logic [BITSIZE:0]   att_sum, dec_diff, rel_diff;

    assign tick    = lrclk & ~lrclk_q;
    // Negative sustain clamps to 0; the positive range already fits below MAX.
    assign sus_lvl = sustain_level[BITSIZE-1] ? '0 : sustain_level[BITSIZE-2:0];

    // One extra bit beyond BITSIZE keeps the sign of an underflowing subtraction.
    assign att_sum  = {2'b00, level_q} + {1'b0, attack_rate};
    assign dec_diff = {2'b00, level_q} - {1'b0, decay_rate};
    assign rel_diff = {2'b00, level_q} - {1'b0, release_rate};

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (gate) state_d = ATTACK;
                end
                ATTACK: begin
                    if (!gate) begin
                        state_d = RELEASE;
                    end else if (att_sum >= {2'b00, MAX}) begin
                        level_d = MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = att_sum[BITSIZE-2:0];
                    end
                end
                DECAY: begin
                    if (!gate) begin
                        state_d = RELEASE;
                    end else if ($signed(dec_diff) <= $signed({2'b00, sus_lvl})) begin
                        level_d = sus_lvl;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = dec_diff[BITSIZE-2:0];
                    end
                end
                SUSTAIN: begin
                    if (!gate) state_d = RELEASE;
                    else       level_d = sus_lvl;
                end
                RELEASE: begin
                    if (gate) begin
                        state_d = ATTACK;
                    end else if ($signed(rel_diff) <= $signed(ZERO_X)) begin
                        level_d = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = rel_diff[BITSIZE-2:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                end
            endcase
        end
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            level_q  <= '0;
            lrclk_q  <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            lrclk_q  <= lrclk;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign out    = {1'b0, level_q};
    assign state  = state_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed bench for envelope_generator with hand-computed ADSR values (BITSIZE=16).
module tb_envelope_generator;

    logic        bclk = 1'b0;
    logic        rst_n;
    logic        lrclk;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] out;
    logic [2:0]  state;
    logic        active, done;

    int total = 0;
    int bad   = 0;
    logic done_at, done_next;

    envelope_generator #(.BITSIZE(16)) dut (
        .bclk(bclk), .rst_n(rst_n), .lrclk(lrclk), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate),
        .sustain_level(sustain_level), .release_rate(release_rate),
        .out(out), .state(state), .active(active), .done(done)
    );

    always #5 bclk = ~bclk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One sample tick; done is captured right after the tick edge and one bclk later.
    task automatic tick(input int high_cycles = 1);
        @(negedge bclk); lrclk = 1'b1;
        @(negedge bclk); done_at = done;
        repeat (high_cycles - 1) @(negedge bclk);
        lrclk = 1'b0;
        if (high_cycles == 1) begin
            @(negedge bclk); done_next = done;
        end else begin
            done_next = done;
        end
        repeat (2) @(negedge bclk);
    endtask

    task automatic expect_tick(input string tag, input int o, input int s);
        tick();
        check({tag, "_out"}, int'(out), o);
        check({tag, "_st"}, int'(state), s);
    endtask

    initial begin
        rst_n = 1'b0; lrclk = 1'b0; gate = 1'b0;
        attack_rate = 16'd10000; decay_rate = 16'd5000;
        sustain_level = 16'd20000; release_rate = 16'd8000;
        repeat (3) @(negedge bclk);
        check("rst_out", int'(out), 0);
        check("rst_st", int'(state), 0);
        check("rst_active", int'(active), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge bclk);

        gate = 1'b1;
        expect_tick("t1", 0, 1);
        check("t1_active", int'(active), 1);
        expect_tick("t2", 10000, 1);
        expect_tick("t3", 20000, 1);
        expect_tick("t4", 30000, 1);
        expect_tick("t5", 32767, 2);
        expect_tick("t6", 27767, 2);
        expect_tick("t7", 22767, 2);
        expect_tick("t8", 20000, 3);
        sustain_level = 16'd25000;
        expect_tick("sus_up", 25000, 3);
        sustain_level = 16'd20000;
        expect_tick("sus_dn", 20000, 3);

        gate = 1'b0;
        expect_tick("rel1", 20000, 4);
        expect_tick("rel2", 12000, 4);
        check("rel2_done", int'(done_at), 0);
        gate = 1'b1;
        expect_tick("retrig1", 12000, 1);
        expect_tick("retrig2", 22000, 1);
        gate = 1'b0;
        expect_tick("rel3", 22000, 4);
        expect_tick("rel4", 14000, 4);
        expect_tick("rel5", 6000, 4);
        expect_tick("rel_end", 0, 0);
        check("done_pulse", int'(done_at), 1);
        check("done_clear", int'(done_next), 0);
        check("rel_end_active", int'(active), 0);

        // Long lrclk high periods must give exactly one update each.
        gate = 1'b1;
        tick(40);
        check("long1_out", int'(out), 0);
        check("long1_st", int'(state), 1);
        tick(40);
        check("long2_out", int'(out), 10000);
        gate = 1'b0;
        repeat (3) @(negedge bclk);
        gate = 1'b1;
        repeat (3) @(negedge bclk);
        check("glitch_out", int'(out), 10000);
        check("glitch_st", int'(state), 1);
        expect_tick("pre_rst", 20000, 1);

        // Asynchronous reset between edges.
        @(negedge bclk); #1 rst_n = 1'b0;
        #1;
        check("arst_out", int'(out), 0);
        check("arst_st", int'(state), 0);
        check("arst_active", int'(active), 0);
        @(negedge bclk); rst_n = 1'b1;
        repeat (5) @(negedge bclk);
        check("post_rst_st", int'(state), 0);
        check("post_rst_out", int'(out), 0);

        attack_rate = 16'd0;
        expect_tick("z1", 0, 1);
        expect_tick("zero_rate", 0, 1);
        attack_rate = 16'd40000;
        expect_tick("big_att", 32767, 2);
        sustain_level = 16'd32767;
        expect_tick("smax", 32767, 3);
        sustain_level = 16'hFFFB;
        expect_tick("sneg", 0, 3);
        check("sneg_active", int'(active), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- ADSR envelope generator, one update per audio sample.
- Runs in the bclk domain; uses lrclk rising edges as the sample tick.
- Output is a non-negative signed envelope that drives the modulator's in2 (tremolo/VCA depth) or a mixer gain input.
- Gate comes from the control/register block.

Parameters:
- BITSIZE, 16, width of the envelope output and all rate/level inputs.

Ports:
- bclk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- lrclk  input  1  sample clock, synchronous to bclk; each rising edge is one sample tick.
- gate  input  1  note on (1) / note off (0); sampled only on a tick.
- attack_rate  input  BITSIZE  unsigned increment per tick in ATTACK.
- decay_rate  input  BITSIZE  unsigned decrement per tick in DECAY.
- sustain_level  input  BITSIZE  signed sustain target; values <0 are treated as 0.
- release_rate  input  BITSIZE  unsigned decrement per tick in RELEASE.
- out  output  BITSIZE  signed envelope, range 0..MAX, where MAX = 2^(BITSIZE-1)-1.
- state  output  3  0=IDLE, 1=ATTACK, 2=DECAY, 3=SUSTAIN, 4=RELEASE.
- active  output  1  high whenever state != IDLE.
- done  output  1  one-bclk pulse on the tick where RELEASE→IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - out=0, state=IDLE, active=0, done=0, lrclk_q=0.
  - Takes effect immediately, including mid-envelope.
  - After release, first tick needs a fresh lrclk rising edge.
- Tick detection:
  - lrclk_q registers lrclk every bclk.
  - tick = lrclk & ~lrclk_q.
  - Exactly one tick per lrclk high period, however long lrclk stays high.
- Update timing:
  - All updates occur only on a tick edge; out, state and done are registered at that same bclk edge.
  - Latency: lrclk rise sampled at edge N → new out visible after edge N.
  - No change between ticks; done is cleared on every non-tick edge.
- Arithmetic:
  - Internal level is unsigned BITSIZE-1 bits.
  - Add/subtract are done in BITSIZE+1 bits, then saturated to [0, MAX].
  - S = clamp(sustain_level, 0, MAX), evaluated live each tick.
- Per-tick transitions (gate = value sampled at the tick):
  - IDLE: gate=1 → ATTACK, level stays 0. gate=0 → stay.
  - ATTACK: gate=0 → RELEASE, no step this tick. Else level += attack_rate; if result ≥ MAX → level=MAX and go to DECAY.
  - DECAY: gate=0 → RELEASE, no step. Else level -= decay_rate; if result ≤ S → level=S and go to SUSTAIN.
  - SUSTAIN: gate=0 → RELEASE, no step. Else level = S, tracking live sustain changes including upward jumps.
  - RELEASE: gate=1 → ATTACK (retrigger from current level, no reset to 0). Else level -= release_rate; if result ≤ 0 → level=0, go to IDLE, done=1.
- Boundary cases:
  - A zero rate holds the level indefinitely in that state.
  - Rate ≥ distance to target reaches the target in one tick.
  - S=MAX → DECAY exits on its first tick with level=MAX.
  - S=0 → SUSTAIN holds 0 but active stays 1.
  - A gate toggle shorter than one sample period, with no tick in between, is invisible.
  - Inputs may change at any time; only tick-edge values matter.
- Encodings: unused state values 5–7 are unreachable and recover to IDLE on the next tick.

Test Plan:
All scenarios use BITSIZE=16 (MAX=32767). Ticks are numbered t1, t2, … from gate rise.
- Attack: gate=1, attack_rate=10000.
  - t1: out=0, state=1.
  - t2: 10000. t3: 20000. t4: 30000.
  - t5: out=32767, state=2.
- Decay/sustain, continuing with decay_rate=5000, sustain_level=20000:
  - t6: 27767. t7: 22767.
  - t8: out=20000, state=3.
  - Change sustain_level to 25000 → next tick out=25000.
- Release: from SUSTAIN at 20000, gate=0, release_rate=8000.
  - Tick: state=4, out=20000.
  - Then 12000, then 4000.
  - Then out=0, state=0, done high for exactly one bclk, active=0.
- Retrigger: gate=1 while in RELEASE at out=12000, attack_rate=10000.
  - Tick: state=1, out=12000.
  - Next tick: 22000.
- Tick qualification: hold lrclk high for 40 bclk → exactly one update. Toggle gate between ticks → no state change.
- Reset mid-operation: rst_n=0 during ATTACK at out=20000 → out=0, state=0 immediately without a bclk edge. After release, nothing changes until the next lrclk rise.
